// File: rtl/core_run_controller_if.sv
// core_run_controller_if: command, core-control, debug-port and dump-stream signals of the run controller
interface core_run_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [CNT_WIDTH-1:0]  cmd_arg;
    logic [DATA_WIDTH-1:0] pc;
    logic                  bp_en;
    logic [DATA_WIDTH-1:0] bp_addr;
    logic                  core_en;
    logic [4:0]            debug_sel;
    logic [DATA_WIDTH-1:0] debug_data;
    logic                  dump_valid;
    logic                  dump_ready;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_last;
    logic                  halted;
    logic                  bp_hit;

    // Environment side: command decoder, datapath and UART TX.
    modport master (
        output cmd_valid, cmd_op, cmd_arg, pc, bp_en, bp_addr, debug_data, dump_ready,
        input  cmd_ready, core_en, debug_sel, dump_valid, dump_data, dump_last, halted, bp_hit
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, pc, bp_en, bp_addr, debug_data, dump_ready,
        output cmd_ready, core_en, debug_sel, dump_valid, dump_data, dump_last, halted, bp_hit
    );
endinterface

// File: rtl/core_run_controller.sv
// core_run_controller: run/halt/step/dump sequencer for the single-cycle core; breakpoint logic under BREAKPOINT_EN
module core_run_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int REG_COUNT  = 32
) (
    input logic                 clk,
    input logic                 reset,
    core_run_controller_if.slave bus
);
    typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, DUMP = 2'd3} state_e;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_DUMP = 2'd3;
    localparam logic [4:0] LAST_IDX = 5'(REG_COUNT - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [4:0]           dump_idx_q, dump_idx_d;
    logic                 bp_hit_q, bp_hit_d;
    logic                 skip_bp_q, skip_bp_d;

    logic cmd_fire, dump_fire, dump_at_last, executing, resume, bp_stop;

    assign cmd_fire     = bus.cmd_valid && bus.cmd_ready;
    assign dump_fire    = bus.dump_valid && bus.dump_ready;
    assign dump_at_last = dump_idx_q == LAST_IDX;
    assign executing    = state_q == RUN || state_q == STEP;
    // A resume re-arms the breakpoint skip so the instruction sitting at bp_addr can retire.
    assign resume       = state_q == HALT && cmd_fire &&
                          (bus.cmd_op == OP_RUN || (bus.cmd_op == OP_STEP && bus.cmd_arg != '0));

`ifdef BREAKPOINT_EN
    assign bp_stop = bus.bp_en && bus.pc == bus.bp_addr && executing && !skip_bp_q;
`else
    logic unused_bp;
    assign bp_stop   = 1'b0;
    assign unused_bp = &{1'b0, bus.bp_en, bus.bp_addr, skip_bp_q, bp_hit_q};
`endif

    // State and counters; reset wins over any command or handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HALT;
            step_cnt_q <= '0;
            dump_idx_q <= '0;
            bp_hit_q   <= 1'b0;
            skip_bp_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            dump_idx_q <= dump_idx_d;
            bp_hit_q   <= bp_hit_d;
            skip_bp_q  <= skip_bp_d;
        end
    end

    // Next state: breakpoint stop outranks a same-cycle HALT command.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT: if (cmd_fire)
                state_d = bus.cmd_op == OP_RUN  ? RUN  :
                          bus.cmd_op == OP_DUMP ? DUMP :
                          resume                ? STEP : HALT;
            RUN:  if (bp_stop || (cmd_fire && bus.cmd_op == OP_HALT)) state_d = HALT;
            STEP: if (bp_stop || step_cnt_q == CNT_WIDTH'(1)) state_d = HALT;
            DUMP: if (dump_fire && dump_at_last) state_d = HALT;
        endcase
        step_cnt_d = bp_stop                                                   ? '0 :
                     state_q == HALT && cmd_fire && bus.cmd_op == OP_STEP      ? bus.cmd_arg :
                     state_q == STEP                                           ? step_cnt_q - CNT_WIDTH'(1) :
                                                                                 step_cnt_q;
        dump_idx_d = state_q == HALT && cmd_fire && bus.cmd_op == OP_DUMP ? 5'd0 :
                     dump_fire                                           ? (dump_at_last ? 5'd0 : dump_idx_q + 5'd1) :
                                                                           dump_idx_q;
        bp_hit_d   = bp_stop ? 1'b1 : resume ? 1'b0 : bp_hit_q;
        skip_bp_d  = resume ? 1'b1 : executing ? 1'b0 : skip_bp_q;
    end

    // Outputs: the core is frozen in DUMP, so debug_data stays stable while TX stalls.
    always_comb begin
        bus.cmd_ready  = state_q == HALT || state_q == RUN;
        bus.core_en    = executing && !bp_stop;
        bus.debug_sel  = state_q == DUMP ? dump_idx_q : 5'd0;
        bus.dump_valid = state_q == DUMP;
        bus.dump_data  = bus.debug_data;
        bus.dump_last  = state_q == DUMP && dump_at_last;
        bus.halted     = state_q == HALT;
`ifdef BREAKPOINT_EN
        bus.bp_hit     = bp_hit_q;
`else
        bus.bp_hit     = 1'b0;
`endif
    end
endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller: scoreboard bench for the run/halt/step/dump sequencer
module tb_core_run_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    core_run_controller_if bus();
    core_run_controller dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    // Register file model: register i holds i*0x11.
    always_comb bus.debug_data = 32'(bus.debug_sel) * 32'h11;

    // Datapath model: PC advances by 4 on every retired instruction.
    always @(posedge clk)
        if (reset) bus.pc <= '0;
        else if (bus.core_en) bus.pc <= bus.pc + 32'd4;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        beat_t e;
        logic [31:0] pc0;
        logic seen, ready_bad, valid_bad;
        int beats, cyc;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'd0;
        bus.cmd_arg    = '0;
        bus.bp_en      = 1'b0;
        bus.bp_addr    = '0;
        bus.dump_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_halted", 64'(bus.halted), 64'(1));
        check("rst_core_en", 64'(bus.core_en), 64'(0));
        check("rst_debug_sel", 64'(bus.debug_sel), 64'(0));
        check("rst_dump_valid", 64'(bus.dump_valid), 64'(0));
        check("rst_dump_last", 64'(bus.dump_last), 64'(0));
        check("rst_bp_hit", 64'(bus.bp_hit), 64'(0));
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        reset = 1'b0;
        tick();

        // STEP 3: exactly three enabled cycles, then halted.
        send(2'd2, 16'd3);
        for (int i = 0; i < 3; i++) begin
            check("step_en", 64'(bus.core_en), 64'(1));
            tick();
        end
        check("step_done_en", 64'(bus.core_en), 64'(0));
        check("step_done_halted", 64'(bus.halted), 64'(1));
        check("step_pc", 64'(bus.pc), 64'(12));

        // STEP 0: never enables the core.
        send(2'd2, 16'd0);
        seen = 1'b0;
        repeat (4) begin
            seen |= bus.core_en;
            tick();
        end
        check("step0_en", 64'(seen), 64'(0));
        check("step0_halted", 64'(bus.halted), 64'(1));

        // RUN at t0, STEP ignored at t3, HALT at t10: ten retiring cycles.
        pc0 = bus.pc;
        send(2'd1, 16'd0);
        for (int i = 1; i <= 10; i++) begin
            check("run_en", 64'(bus.core_en), 64'(1));
            bus.cmd_valid = i == 3 || i == 10;
            bus.cmd_op    = i == 3 ? 2'd2 : 2'd0;
            bus.cmd_arg   = 16'd5;
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("run_stop_en", 64'(bus.core_en), 64'(0));
        check("run_stop_halted", 64'(bus.halted), 64'(1));
        check("run_pc", 64'(bus.pc), 64'(pc0 + 32'd40));
        tick();
        check("run_after_en", 64'(bus.core_en), 64'(0));

        // DUMP with toggling ready: expected beats queued up front, popped per handshake.
        for (int i = 0; i < 32; i++) begin
            e.sel  = 5'(i);
            e.data = 32'(i) * 32'h11;
            e.last = i == 31;
            sb.push_back(e);
        end
        send(2'd3, 16'd0);
        beats = 0;
        cyc = 0;
        ready_bad = 1'b0;
        valid_bad = 1'b0;
        while (beats < 32 && cyc < 200) begin
            bus.dump_ready = cyc % 2 == 0;
            ready_bad |= bus.cmd_ready;
            valid_bad |= !bus.dump_valid;
            if (bus.dump_valid && bus.dump_ready) begin
                e = sb.pop_front();
                check("dump_beat", 64'({bus.debug_sel, bus.dump_data, bus.dump_last}),
                      64'({e.sel, e.data, e.last}));
                beats++;
            end
            tick();
            cyc++;
        end
        bus.dump_ready = 1'b0;
        check("dump_beats", 64'(beats), 64'(32));
        check("dump_cmd_ready", 64'(ready_bad), 64'(0));
        check("dump_valid_held", 64'(valid_bad), 64'(0));
        check("dump_end_halted", 64'(bus.halted), 64'(1));
        check("dump_end_valid", 64'(bus.dump_valid), 64'(0));
        check("dump_sb_empty", 64'(sb.size()), 64'(0));

        // Breakpoint at 0x10 with PC starting from 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h10;
        send(2'd1, 16'd0);
`ifdef BREAKPOINT_EN
        cyc = 0;
        while (!bus.halted && cyc < 20) begin
            tick();
            cyc++;
        end
        check("bp_halted", 64'(bus.halted), 64'(1));
        check("bp_pc", 64'(bus.pc), 64'(32'h10));
        check("bp_hit", 64'(bus.bp_hit), 64'(1));
        check("bp_core_en", 64'(bus.core_en), 64'(0));
        send(2'd1, 16'd0);
        check("bp_resume_en", 64'(bus.core_en), 64'(1));
        check("bp_resume_hit", 64'(bus.bp_hit), 64'(0));
        tick();
        check("bp_resume_pc", 64'(bus.pc), 64'(32'h14));
`else
        repeat (6) tick();
        check("nobp_pc", 64'(bus.pc), 64'(32'h18));
        check("nobp_core_en", 64'(bus.core_en), 64'(1));
        check("nobp_hit", 64'(bus.bp_hit), 64'(0));
`endif
        send(2'd0, 16'd0);
        check("bp_final_halted", 64'(bus.halted), 64'(1));
        bus.bp_en = 1'b0;

        // Reset in the middle of a dump, then a fresh dump restarts at index 0.
        bus.dump_ready = 1'b1;
        send(2'd3, 16'd0);
        repeat (7) tick();
        check("mid_dump_sel", 64'(bus.debug_sel), 64'(7));
        reset = 1'b1;
        tick();
        check("mid_rst_halted", 64'(bus.halted), 64'(1));
        check("mid_rst_sel", 64'(bus.debug_sel), 64'(0));
        check("mid_rst_valid", 64'(bus.dump_valid), 64'(0));
        reset = 1'b0;
        bus.dump_ready = 1'b0;
        tick();
        send(2'd3, 16'd0);
        check("redump_sel", 64'(bus.debug_sel), 64'(0));
        check("redump_valid", 64'(bus.dump_valid), 64'(1));
        check("redump_data", 64'(bus.dump_data), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
